// File: rtl/game_frame_timer.sv
// Frame-strobe generator: periodic frame_tick with run/pause, single-step, runtime
// period reload, wrapping frame counter and power-of-two divided ticks.
module game_frame_timer #(
    parameter int CNT_W          = 20,
    parameter int PERIOD_DEFAULT = 1048575,
    parameter int FRAME_W        = 16,
    parameter int NUM_DIV        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    input  logic               step,
    input  logic [CNT_W-1:0]   period_in,
    input  logic               period_load,
    output logic               frame_tick,
    output logic [NUM_DIV-1:0] div_tick,
    output logic [FRAME_W-1:0] frame_count,
    output logic               paused
);

    typedef enum logic [1:0] {S_RUN, S_PAUSED, S_STEP} state_t;

    localparam logic [CNT_W-1:0]   PERIOD_RST = CNT_W'(PERIOD_DEFAULT);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   PERIOD_MIN = CNT_W'(2);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   period_reg, period_nxt;
    logic               tick_nxt;
    logic [FRAME_W-1:0] fc_nxt;

    // A period below 2 would leave no cycle between consecutive wraps.
    function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W-1:0] p);
        return (p < PERIOD_MIN) ? PERIOD_MIN : p;
    endfunction

    // Bit i set when the low i+1 bits of the new frame count are all zero.
    function automatic logic [NUM_DIV-1:0] div_mask(input logic [FRAME_W-1:0] fc);
        logic [FRAME_W-1:0] m;
        logic [NUM_DIV-1:0] r;
        m = '0;
        r = '0;
        for (int i = 0; i < NUM_DIV; i++) begin
            m[i] = 1'b1;
            r[i] = ((fc & m) == '0);
        end
        return r;
    endfunction

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period_reg;
        tick_nxt   = 1'b0;
        case (state)
            S_RUN: begin
                if (!run_en) begin
                    state_nxt = S_PAUSED;
                end else if (cnt == period_reg - CNT_ONE) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_PAUSED: begin
                if (run_en) begin
                    state_nxt = S_RUN;
                end else if (step) begin
                    state_nxt = S_STEP;
                    cnt_nxt   = '0;
                    tick_nxt  = 1'b1;
                end
            end
            S_STEP: begin
                state_nxt = run_en ? S_RUN : S_PAUSED;
            end
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
        endcase
        // A reload restarts the frame; a wrap landing on the same edge is dropped.
        if (period_load) begin
            period_nxt = sat_period(period_in);
            cnt_nxt    = '0;
            if (state == S_RUN) tick_nxt = 1'b0;
        end
        fc_nxt = frame_count + FRAME_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            cnt         <= '0;
            period_reg  <= PERIOD_RST;
            frame_count <= '0;
            frame_tick  <= 1'b0;
            div_tick    <= '0;
            paused      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_reg <= period_nxt;
            frame_tick <= tick_nxt;
            div_tick   <= tick_nxt ? div_mask(fc_nxt) : '0;
            paused     <= (state_nxt == S_PAUSED);
            if (tick_nxt) frame_count <= fc_nxt;
        end
    end

endmodule
